// File: rtl/darkroom_pkg.sv
// Shared types and default sizing for the darkroom sensor-to-SPI path.
package darkroom_pkg;

  localparam int DR_ID_W         = 4;
  localparam int DR_MAX_BURST    = 8;
  localparam int DR_GAP_CYCLES   = 16;
  localparam int DR_DONE_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  // Width of an SPI word: sensor ID prepended to the sweep record.
  function automatic int word_w(input int id_w, input int data_w);
    return id_w + data_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr
// (wrapping modulo N) wins.
module rr_arbiter #(
  parameter int N     = 12,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_valid
);

  // Rotating priority search starting at the pointer.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!any_valid && req[idx]) begin
        any_valid      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sensor_spi_scheduler.sv
// Shares one SPI transmitter between the lighthouse sensor channels:
// round-robin grant, ID tagging, bounded bursts and inter-frame gaps.
module sensor_spi_scheduler
  import darkroom_pkg::*;
#(
  parameter int NUM_SENSORS  = 12,
  parameter int DATA_W       = 28,
  parameter int ID_W         = DR_ID_W,
  parameter int MAX_BURST    = DR_MAX_BURST,
  parameter int GAP_CYCLES   = DR_GAP_CYCLES,
  parameter int DONE_TIMEOUT = DR_DONE_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trigger_me,
  input  logic [NUM_SENSORS-1:0]        req_valid,
  input  logic [NUM_SENSORS*DATA_W-1:0] req_data,
  output logic [NUM_SENSORS-1:0]        req_ready,
  output logic                          spi_start,
  output logic [word_w(ID_W, DATA_W)-1:0] spi_word,
  input  logic                          spi_busy,
  input  logic                          spi_done,
  output logic                          frame_o,
  output logic [ID_W-1:0]               grant_id,
  output logic [15:0]                   words_sent,
  output logic                          timeout_err
);

  localparam int PTR_W   = $clog2(NUM_SENSORS);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam int TO_W    = $clog2(DONE_TIMEOUT + 1);
  localparam int WORD_W  = word_w(ID_W, DATA_W);

  // The ID field must be able to hold every channel index.
  if (NUM_SENSORS < 2 || NUM_SENSORS > (1 << ID_W)) begin : g_bad_cfg
    $error("sensor_spi_scheduler: NUM_SENSORS must be 2..2**ID_W");
  end

  state_t                   state_reg, state_next;
  logic [PTR_W-1:0]         ptr_reg, ptr_next;
  logic [PTR_W-1:0]         grant_idx_reg, grant_idx_next;
  logic [NUM_SENSORS-1:0]   grant_oh_reg, grant_oh_next;
  logic [WORD_W-1:0]        word_reg, word_next;
  logic [BURST_W-1:0]       burst_reg, burst_next;
  logic [GAP_W-1:0]         gap_reg, gap_next;
  logic [TO_W-1:0]          to_reg, to_next;
  logic [15:0]              words_reg, words_next;
  logic                     terr_reg, terr_next;
  logic                     frame_reg, frame_next;
  logic                     start_fire;

  logic [NUM_SENSORS-1:0]   arb_grant;
  logic [PTR_W-1:0]         arb_idx;
  logic                     arb_any;
  logic [DATA_W-1:0]        arb_record;
  logic [DATA_W-1:0]        masked_rec [NUM_SENSORS];

  rr_arbiter #(
    .N     (NUM_SENSORS),
    .IDX_W (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  // One-hot AND-OR mux of the winning channel's record.
  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_mask
    assign masked_rec[gi] = req_data[gi*DATA_W +: DATA_W] & {DATA_W{arb_grant[gi]}};
  end

  // Collapse the masked records into the granted one.
  always_comb begin
    arb_record = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      arb_record = arb_record | masked_rec[i];
    end
  end

  // Next-state and datapath updates for the scheduler FSM.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_idx_next = grant_idx_reg;
    grant_oh_next  = grant_oh_reg;
    word_next      = word_reg;
    burst_next     = burst_reg;
    gap_next       = gap_reg;
    to_next        = to_reg;
    words_next     = words_reg;
    terr_next      = terr_reg;
    frame_next     = frame_reg;
    start_fire     = 1'b0;
    case (state_reg)
      IDLE: begin
        frame_next = 1'b0;
        if (trigger_me && arb_any) state_next = ARB;
      end
      ARB: begin
        if (arb_any) begin
          grant_idx_next = arb_idx;
          grant_oh_next  = arb_grant;
          word_next      = {ID_W'(arb_idx), arb_record};
          state_next     = START;
        end else if (frame_reg) begin
          gap_next   = '0;
          frame_next = 1'b0;
          state_next = GAP;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (!spi_busy) begin
          // Never acknowledge a channel that has withdrawn its request.
          if (|(req_valid & grant_oh_reg)) begin
            start_fire = 1'b1;
            ptr_next   = (grant_idx_reg == PTR_W'(NUM_SENSORS - 1)) ? '0
                                                                     : grant_idx_reg + PTR_W'(1);
            burst_next = burst_reg + BURST_W'(1);
            frame_next = 1'b1;
            to_next    = '0;
            state_next = WAIT_DONE;
          end else begin
            state_next = ARB;
          end
        end
      end
      WAIT_DONE: begin
        if (spi_done) begin
          words_next = words_reg + 16'd1;
          if (trigger_me && (burst_reg < BURST_W'(MAX_BURST)) && arb_any) begin
            state_next = ARB;
          end else begin
            gap_next   = '0;
            frame_next = 1'b0;
            state_next = GAP;
          end
        end else if (to_reg == TO_W'(DONE_TIMEOUT - 1)) begin
          terr_next  = 1'b1;
          gap_next   = '0;
          frame_next = 1'b0;
          state_next = GAP;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
      GAP: begin
        frame_next = 1'b0;
        burst_next = '0;
        if (gap_reg == GAP_W'(GAP_CYCLES - 1)) state_next = IDLE;
        else                                   gap_next   = gap_reg + GAP_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_idx_reg <= '0;
      grant_oh_reg  <= '0;
      word_reg      <= '0;
      burst_reg     <= '0;
      gap_reg       <= '0;
      to_reg        <= '0;
      words_reg     <= '0;
      terr_reg      <= 1'b0;
      frame_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_idx_reg <= grant_idx_next;
      grant_oh_reg  <= grant_oh_next;
      word_reg      <= word_next;
      burst_reg     <= burst_next;
      gap_reg       <= gap_next;
      to_reg        <= to_next;
      words_reg     <= words_next;
      terr_reg      <= terr_next;
      frame_reg     <= frame_next;
    end
  end

  assign spi_start   = start_fire;
  assign req_ready   = start_fire ? grant_oh_reg : '0;
  assign frame_o     = frame_reg | start_fire;
  assign spi_word    = word_reg;
  assign grant_id    = ID_W'(grant_idx_reg);
  assign words_sent  = words_reg;
  assign timeout_err = terr_reg;

endmodule

// File: tb/tb_sensor_spi_scheduler.sv
// Scoreboard bench: stimulus queues expected words, a monitor checks each
// spi_start against the queue, a responder model plays the SPI master.
module tb_sensor_spi_scheduler;

  localparam int NS = 12;
  localparam int DW = 28;
  localparam int DONE_DLY = 10;
  localparam int LOG_N = 16384;

  typedef struct {
    logic [31:0] word;
    logic [11:0] ready;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            trigger_me = 1'b0;
  logic [NS-1:0]   req_valid = '0;
  logic [NS*DW-1:0] req_data = '0;
  logic [NS-1:0]   req_ready;
  logic            spi_start;
  logic [31:0]     spi_word;
  logic            spi_busy = 1'b0;
  logic            resp_done = 1'b0;
  logic            spur_done = 1'b0;
  logic            frame_o;
  logic [3:0]      grant_id;
  logic [15:0]     words_sent;
  logic            timeout_err;

  bit              no_done = 1'b0;
  int              cyc = 0;
  int              checks = 0;
  int              passes = 0;
  exp_t            exp_q[$];
  int              start_cyc_q[$];
  bit              frame_log [LOG_N];
  exp_t            mon_e;

  sensor_spi_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .trigger_me  (trigger_me),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .spi_start   (spi_start),
    .spi_word    (spi_word),
    .spi_busy    (spi_busy),
    .spi_done    (resp_done | spur_done),
    .frame_o     (frame_o),
    .grant_id    (grant_id),
    .words_sent  (words_sent),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every start must match the head of the expected queue.
  always @(negedge clk) begin
    if (cyc < LOG_N) frame_log[cyc] = frame_o;
    if (spi_start) begin
      start_cyc_q.push_back(cyc);
      $display("start cyc=%0d word=%h ready=%h grant_id=%0d", cyc, spi_word, req_ready, grant_id);
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_start: word=%h ready=%h, no start required", spi_word, req_ready);
      end else begin
        mon_e = exp_q.pop_front();
        if (spi_word === mon_e.word && req_ready === mon_e.ready) passes++;
        else $display("FAIL start_word: word=%h ready=%h, required word=%h ready=%h",
                      spi_word, req_ready, mon_e.word, mon_e.ready);
      end
    end else if (req_ready !== '0) begin
      checks++;
      $display("FAIL stray_ready: ready=%h without spi_start, required 0", req_ready);
    end
  end

  // SPI master model: done pulse DONE_DLY cycles after each start.
  initial begin
    forever begin
      @(negedge clk);
      if (spi_start && !no_done) begin
        repeat (DONE_DLY) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got === req) passes++;
    else $display("FAIL %s: got %h required %h", name, got, req);
  endtask

  task automatic push_exp(input int ch, input logic [27:0] rec);
    exp_t e;
    e.word  = {4'(ch), rec};
    e.ready = 12'(1) << ch;
    exp_q.push_back(e);
  endtask

  task automatic set_rec(input int ch, input logic [27:0] v);
    req_data[ch*DW +: DW] = v;
    req_valid[ch] = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (start_cyc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (start_cyc_q.size() < n) begin
      checks++;
      $display("FAIL %s: saw %0d starts, required %0d", tag, start_cyc_q.size(), n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trigger_me = 1'b0;
    spi_busy = 1'b0;
    req_valid = '0;
    req_data = '0;
    spur_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    start_cyc_q.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_start"},   32'(spi_start), 32'd0);
    chk({tag, "_ready"},   32'(req_ready), 32'd0);
    chk({tag, "_word"},    spi_word, 32'd0);
    chk({tag, "_frame"},   32'(frame_o), 32'd0);
    chk({tag, "_grant"},   32'(grant_id), 32'd0);
    chk({tag, "_words"},   32'(words_sent), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s0, te;

    // Reset state.
    repeat (2) tick();
    chk_zero_outputs("reset");
    do_reset();

    // Full rotation: bursts of 8, gap, then continue from channel 8.
    for (int i = 0; i < NS; i++) set_rec(i, 28'h5A00000 + 28'(i));
    for (int i = 0; i < 8; i++) push_exp(i, 28'h5A00000 + 28'(i));
    for (int i = 8; i < 12; i++) push_exp(i, 28'h5A00000 + 28'(i));
    for (int i = 0; i < 4; i++) push_exp(i, 28'h5A00000 + 28'(i));
    tick();
    trigger_me = 1'b1;
    t0 = cyc;
    wait_starts(16, 2000, "rr_starts");
    tick();
    trigger_me = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    chk("rr_words_sent", 32'(words_sent), 32'd16);
    if (start_cyc_q.size() >= 16) begin
      chk("rr_first_latency", 32'(start_cyc_q[0] - t0), 32'd2);
      chk("rr_word_spacing", 32'(start_cyc_q[1] - start_cyc_q[0]), 32'd12);
      chk("rr_gap_spacing", 32'(start_cyc_q[8] - start_cyc_q[7]), 32'd29);
      chk("rr_frame_before_drop", 32'(frame_log[start_cyc_q[7] + 10]), 32'd1);
      chk("rr_frame_after_drop", 32'(frame_log[start_cyc_q[7] + 11]), 32'd0);
    end

    // Two sparse channels alternate.
    do_reset();
    set_rec(3, 28'hABCDEF1);
    set_rec(9, 28'hABCDEF1);
    push_exp(3, 28'hABCDEF1);
    push_exp(9, 28'hABCDEF1);
    push_exp(3, 28'hABCDEF1);
    push_exp(9, 28'hABCDEF1);
    trigger_me = 1'b1;
    wait_starts(4, 300, "alt_starts");
    tick();
    trigger_me = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    chk("alt_words_sent", 32'(words_sent), 32'd4);
    chk("alt_frame_idle", 32'(frame_o), 32'd0);

    // Busy holds off the start until the first non-busy cycle.
    do_reset();
    set_rec(5, 28'h0000055);
    push_exp(5, 28'h0000055);
    tick();
    spi_busy = 1'b1;
    trigger_me = 1'b1;
    t0 = cyc;
    repeat (6) tick();
    spi_busy = 1'b0;
    wait_starts(1, 50, "busy_start");
    tick();
    trigger_me = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    if (start_cyc_q.size() >= 1) chk("busy_start_cycle", 32'(start_cyc_q[0] - t0), 32'd6);
    chk("busy_words_sent", 32'(words_sent), 32'd1);

    // Done timeout: sticky error, word not counted, next grant after gap.
    do_reset();
    no_done = 1'b1;
    set_rec(2, 28'h2222222);
    push_exp(2, 28'h2222222);
    push_exp(2, 28'h2222222);
    trigger_me = 1'b1;
    wait_starts(1, 50, "to_first_start");
    s0 = (start_cyc_q.size() >= 1) ? start_cyc_q[0] : 0;
    te = 0;
    while (timeout_err !== 1'b1 && te < 1200) begin
      @(negedge clk);
      te++;
    end
    chk("to_err_cycle", 32'(cyc - s0), 32'd1025);
    chk("to_frame", 32'(frame_o), 32'd0);
    chk("to_words_sent", 32'(words_sent), 32'd0);
    no_done = 1'b0;
    wait_starts(2, 100, "to_second_start");
    tick();
    trigger_me = 1'b0;
    if (start_cyc_q.size() >= 2) chk("to_regrant_cycle", 32'(start_cyc_q[1] - s0), 32'd1043);
    repeat (40) tick();
    @(negedge clk);
    chk("to_words_after", 32'(words_sent), 32'd1);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);

    // trigger_me dropped while word 3 is in flight.
    do_reset();
    for (int i = 0; i < 6; i++) set_rec(i, 28'h5550000 + 28'(i));
    for (int i = 0; i < 3; i++) push_exp(i, 28'h5550000 + 28'(i));
    trigger_me = 1'b1;
    wait_starts(3, 200, "trig_starts");
    tick();
    trigger_me = 1'b0;
    repeat (60) tick();
    @(negedge clk);
    chk("trig_words_sent", 32'(words_sent), 32'd3);
    chk("trig_frame", 32'(frame_o), 32'd0);
    chk("trig_start_count", 32'(start_cyc_q.size()), 32'd3);

    // Reset in WAIT_DONE plus a spurious done; pointer returns to 0.
    do_reset();
    no_done = 1'b1;
    set_rec(4, 28'h4444444);
    set_rec(7, 28'h7777777);
    push_exp(4, 28'h4444444);
    trigger_me = 1'b1;
    wait_starts(1, 50, "rst_first_start");
    repeat (3) tick();
    reset = 1'b1;
    trigger_me = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    chk_zero_outputs("rst_mid");
    no_done = 1'b0;
    push_exp(4, 28'h4444444);
    tick();
    trigger_me = 1'b1;
    wait_starts(2, 50, "rst_regrant");
    tick();
    trigger_me = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    chk("rst_words_sent", 32'(words_sent), 32'd1);
    chk("rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sensor_spi_scheduler.md
Name: sensor_spi_scheduler

Overview:
Round-robin scheduler that shares the single darkroom SPI transmitter between the 12 lighthouse sensor channels. Each channel presents a timestamped sweep record with valid/ready. The scheduler picks one channel per word, tags the word with the sensor ID, and sequences the SPI master through start/done handshakes. Words are grouped into bounded bursts with inter-frame gaps, gated by trigger_me. It sits between the per-sensor pulse decoders and the SPI master that drives mosi/sck/ss_n.

Parameters:
NUM_SENSORS, 12, number of requesting sensor channels (2..16)
DATA_W, 28, sweep record width per channel
ID_W, 4, sensor ID field width; word = {id, record}
MAX_BURST, 8, max words per SPI frame before a forced gap
GAP_CYCLES, 16, idle cycles between frames (ss_n high time)
DONE_TIMEOUT, 1024, max cycles waiting for spi_done

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
trigger_me  in  1  transmission enable; level sensitive
req_valid  in  NUM_SENSORS  per-channel record available
req_data  in  NUM_SENSORS*DATA_W  packed records, channel i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_SENSORS  one-hot, 1-cycle pulse; record consumed
spi_start  out  1  1-cycle pulse; SPI master latches spi_word
spi_word  out  ID_W+DATA_W  {grant_id, record}; held stable from start until done
spi_busy  in  1  SPI master busy
spi_done  in  1  1-cycle pulse; word shifted out
frame_o  out  1  high for the whole burst; the SPI master uses it for ss_n framing
grant_id  out  ID_W  ID of the last granted channel
words_sent  out  16  count of completed words; wraps 0xFFFF->0
timeout_err  out  1  sticky; set on a done timeout, cleared only by reset

Behaviour:
- Reset values (sync, active-high): all outputs 0, RR pointer 0, state IDLE, counters 0. Reset during any state aborts the current word. An spi_done arriving after reset is ignored.
- States: IDLE, ARB, START, WAIT_DONE, GAP.
- IDLE: when trigger_me=1 and |req_valid, go to ARB. frame_o=0.
- ARB (1 cycle):
  - Search starts at the pointer and runs upward mod NUM_SENSORS; the first valid channel wins.
  - Latch spi_word and grant_id, then go to START.
  - If no request is valid (valid dropped), go to GAP when frame_o=1, otherwise IDLE.
- START:
  - Waits while spi_busy=1.
  - When spi_busy=0, in the same cycle: spi_start=1, req_ready[g]=1, frame_o=1, pointer=(g+1) mod NUM_SENSORS, burst_cnt++. Then go to WAIT_DONE.
  - Latency from ARB entry to spi_start is 2 cycles when spi_busy=0.
- WAIT_DONE:
  - spi_done=1: words_sent++ (wraps). Go to ARB if all three hold: trigger_me=1, burst_cnt<MAX_BURST, |req_valid. Otherwise go to GAP.
  - Timeout counter reaches DONE_TIMEOUT with no done: set timeout_err, go to GAP. The word is not counted.
- GAP:
  - frame_o=0, burst_cnt=0.
  - Counts GAP_CYCLES, then goes to IDLE. New requests are not granted during the gap.
- trigger_me falling mid-burst: the current word completes normally; the frame ends after its done.
- Simultaneous spi_done and a new req_valid on the same channel: the record is eligible only after the pointer has advanced, so rotation order is preserved.
- req_valid for a channel must stay asserted until its req_ready. The scheduler never pulses req_ready for a channel whose valid=0.
- ID field = channel index zero-extended to ID_W. NUM_SENSORS ≤ 2^ID_W is checked at elaboration.

Decomposition:
- Package darkroom_pkg:
  - state enum
  - ID_W
  - word-width helper
  - localparams MAX_BURST, GAP_CYCLES, DONE_TIMEOUT defaults
- Sub-module rr_arbiter:
  - Parameterised on N.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_valid.
  - Purely combinational, reused by the OOTX decoder path later.

Test Plan:
- All 12 channels valid, trigger_me=1, done 10 cycles after each start → grants in order 0,1,...,7, frame_o drops after the 8th done, 16-cycle gap, then grants 8..11,0..3. words_sent=16.
- Only channels 3 and 9 valid, record 0xABCDEF1 → spi_word=0x3ABCDEF1 then 0x9xxxxxxx, alternating. Each req_ready pulse lands in its spi_start cycle.
- spi_busy held high 5 cycles after ARB → spi_start delayed exactly until the first cycle busy=0. No double start.
- No spi_done for 1024 cycles → timeout_err=1, frame_o=0, words_sent unchanged. The next grant proceeds after the gap.
- trigger_me dropped during WAIT_DONE of word 3 → done completes the word, the frame ends, no further starts while trigger_me=0.
- reset asserted in WAIT_DONE, then a spurious spi_done → all outputs 0, pointer 0, words_sent stays 0. The first grant afterwards goes to the lowest valid channel.
